// File: rtl/calorie_pkg.sv
// Shared constants and types for the day-01 calorie tracker front end.
// The ASCII byte classes and the parser state encoding live here so the bench can decode state_dbg.
package calorie_pkg;

   localparam int CAL_W = 32;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      NUM    = 3'd1,
      SETTLE = 3'd2,
      STORE  = 3'd3,
      DRAIN  = 3'd4,
      READ   = 3'd5,
      DONE   = 3'd6
   } parser_state_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_0) && (b <= ASCII_9);
   endfunction

endpackage

// File: rtl/ascii_dec_acc.sv
// Decimal accumulator: decodes an ASCII digit and folds it into acc = acc*10 + d,
// saturating at all-ones and flagging ovf for the cycle in which saturation happens.
module ascii_dec_acc
   import calorie_pkg::*;
#(
   parameter int DATA_W = CAL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              digit_vld,
   input  logic [7:0]        digit,
   input  logic              clear,
   output logic [DATA_W-1:0] acc,
   output logic              ovf
);

   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] acc_d;
   logic [DATA_W+3:0] next_w;
   logic [3:0]        dig_val;
   logic              dig_ok;

   always_comb begin
      dig_ok  = is_digit(digit);
      dig_val = digit[3:0];
      // acc*10 as (acc<<3)+(acc<<1); four spare bits hold anything up to 10*(2^W-1)+9
      next_w  = {1'b0, acc_q, 3'b000} + {3'b000, acc_q, 1'b0} + {{DATA_W{1'b0}}, dig_val};
      acc_d   = acc_q;
      ovf     = 1'b0;
      if (clear) begin
         acc_d = '0;
      end else if (digit_vld && dig_ok) begin
         if (next_w[DATA_W+3:DATA_W] != 4'd0) begin
            acc_d = '1;
            ovf   = 1'b1;
         end else begin
            acc_d = next_w[DATA_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/calorie_text_parser.sv
// ASCII front end of the calorie tracker: turns the puzzle text into food_vld / store_sum /
// read_max strobes, holding off store_sum until the tracker has settled after the last item.
module calorie_text_parser
   import calorie_pkg::*;
#(
   parameter int DATA_W        = CAL_W,
   parameter int SETTLE_CYCLES = 2,
   parameter int GRP_CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           in_data,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic                 in_last,
   output logic [DATA_W-1:0]    food_calories,
   output logic                 food_vld,
   output logic                 store_sum,
   output logic                 read_max,
   output logic                 done,
   output logic                 parse_err,
   output logic                 ovf_err,
   output logic [GRP_CNT_W-1:0] group_count,
   output parser_state_t        state_dbg
);

   // Input handshake: a byte (with its in_last) transfers on a rising edge where
   // in_vld & in_rdy; in_vld may drop at any time and in_rdy does not depend on in_vld.
   localparam int                SET_W    = $clog2(SETTLE_CYCLES + 2);
   localparam logic [SET_W-1:0]  SETTLE_N = SET_W'(SETTLE_CYCLES);

   parser_state_t         state_q, state_d;
   logic                  last_q, last_d;
   logic                  grp_q, grp_d;
   logic [SET_W-1:0]      cnt_q, cnt_d;
   logic                  in_rdy_q, in_rdy_d;
   logic                  food_vld_q, food_vld_d;
   logic [DATA_W-1:0]     food_cal_q, food_cal_d;
   logic                  store_q, store_d;
   logic                  read_q, read_d;
   logic                  done_q, done_d;
   logic                  perr_q, perr_d;
   logic                  oerr_q, oerr_d;
   logic [GRP_CNT_W-1:0]  gcnt_q, gcnt_d;

   logic                  accept;
   logic                  b_digit;
   logic                  b_lf;
   logic                  b_cr;
   logic                  emit;
   logic                  acc_clear;
   logic                  acc_ovf;
   logic [DATA_W-1:0]     acc;

   ascii_dec_acc #(
      .DATA_W (DATA_W)
   ) u_acc (
      .clk       (clk),
      .rst       (rst),
      .digit_vld (accept),
      .digit     (in_data),
      .clear     (acc_clear),
      .acc       (acc),
      .ovf       (acc_ovf)
   );

   always_comb begin
      accept     = in_vld & in_rdy_q;
      b_digit    = is_digit(in_data);
      b_lf       = (in_data == ASCII_LF);
      b_cr       = (in_data == ASCII_CR);

      state_d    = state_q;
      last_d     = last_q;
      grp_d      = grp_q;
      cnt_d      = cnt_q;
      food_vld_d = 1'b0;
      food_cal_d = food_cal_q;
      store_d    = 1'b0;
      read_d     = 1'b0;
      done_d     = done_q;
      perr_d     = perr_q;
      oerr_d     = oerr_q | acc_ovf;
      gcnt_d     = gcnt_q;
      emit       = 1'b0;
      acc_clear  = 1'b0;

      if (accept && !b_digit && !b_lf && !b_cr) begin
         perr_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               last_d = in_last;
               if (b_digit) begin
                  state_d = NUM;
               end else if (b_lf && grp_q) begin
                  state_d = SETTLE;
               end
            end else if (last_q) begin
               // Final byte left no digits pending: close the group if there is one.
               state_d = grp_q ? SETTLE : DRAIN;
            end
         end
         NUM: begin
            if (accept) begin
               last_d = in_last;
               if (b_lf) begin
                  emit    = 1'b1;
                  state_d = IDLE;
               end
            end else if (last_q) begin
               // End of input with digits pending behaves like a trailing LF.
               emit    = 1'b1;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q >= SETTLE_N) begin
               state_d = STORE;
               store_d = 1'b1;
               grp_d   = 1'b0;
               if (gcnt_q != {GRP_CNT_W{1'b1}}) begin
                  gcnt_d = gcnt_q + 1'b1;
               end
            end
         end
         STORE: begin
            state_d = last_q ? DRAIN : IDLE;
         end
         DRAIN: begin
            state_d = READ;
            read_d  = 1'b1;
         end
         READ: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (emit) begin
         food_vld_d = 1'b1;
         food_cal_d = acc;
         acc_clear  = 1'b1;
         grp_d      = 1'b1;
      end

      // cnt tracks cycles elapsed since the most recent food_vld, saturating at SETTLE_N.
      if (food_vld_d) begin
         cnt_d = '0;
      end else if (cnt_q < SETTLE_N) begin
         cnt_d = cnt_q + 1'b1;
      end

      in_rdy_d = ((state_d == IDLE) || (state_d == NUM)) && !last_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         last_q     <= 1'b0;
         grp_q      <= 1'b0;
         cnt_q      <= '0;
         in_rdy_q   <= 1'b0;
         food_vld_q <= 1'b0;
         food_cal_q <= '0;
         store_q    <= 1'b0;
         read_q     <= 1'b0;
         done_q     <= 1'b0;
         perr_q     <= 1'b0;
         oerr_q     <= 1'b0;
         gcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grp_q      <= grp_d;
         cnt_q      <= cnt_d;
         in_rdy_q   <= in_rdy_d;
         food_vld_q <= food_vld_d;
         food_cal_q <= food_cal_d;
         store_q    <= store_d;
         read_q     <= read_d;
         done_q     <= done_d;
         perr_q     <= perr_d;
         oerr_q     <= oerr_d;
         gcnt_q     <= gcnt_d;
      end
   end

   assign in_rdy        = in_rdy_q;
   assign food_calories = food_cal_q;
   assign food_vld      = food_vld_q;
   assign store_sum     = store_q;
   assign read_max      = read_q;
   assign done          = done_q;
   assign parse_err     = perr_q;
   assign ovf_err       = oerr_q;
   assign group_count   = gcnt_q;
   assign state_dbg     = state_q;

endmodule
